// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and FSM state encodings shared by the multiply/divide unit
package muldiv_pkg;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FIX   = 2'd2;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration (shift-add multiply or restoring divide); divide path only with MULDIV_DIV_EN
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               mode,
    output logic [2*WIDTH-1:0] next
);
    logic [WIDTH:0] sum;
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] shl;
    logic [WIDTH:0] diff;
    assign shl  = acc[2*WIDTH-1:WIDTH-1];
    assign diff = shl - {1'b0, opnd};
    assign next = !mode ? {sum, acc[WIDTH-1:1]} :
                  diff[WIDTH] ? {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                  {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign next = {sum, acc[WIDTH-1:1]};
`endif
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide with HI/LO registers; divide enabled by MULDIV_DIV_EN
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               zdiv;
    logic               op_div;
    logic               sgn_op;
    logic               a_neg;
    logic               b_neg;
    logic               go;
    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc  (acc),
        .opnd (opnd),
        .mode (is_div),
        .next (acc_nxt)
    );
    // operand magnitudes at issue time and sign-corrected results at the end
    always_comb begin
        op_div = DIV_EN && (op == OP_DIV || op == OP_DIVU);
        go     = state == ST_IDLE && start && (op == OP_MULT || op == OP_MULTU || op_div);
        sgn_op = op == OP_MULT || op == OP_DIV;
        a_neg  = sgn_op && a[WIDTH-1];
        b_neg  = sgn_op && b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        prod   = neg_q ? -acc : acc;
        lo_fix = is_div ? (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod[WIDTH-1:0];
        hi_fix = is_div ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
    end
    // FSM, iteration counter and HI/LO update; divide-by-zero keeps the quotient all ones by suppressing its negation
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            zdiv   <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            dbz  <= 1'b0;
            if (state == ST_IDLE) begin
                if (go) begin
                    acc    <= {{WIDTH{1'b0}}, a_mag};
                    opnd   <= b_mag;
                    is_div <= op_div;
                    neg_q  <= (a_neg ^ b_neg) && b != '0;
                    neg_r  <= a_neg;
                    zdiv   <= b == '0;
                    cnt    <= CNT_W'(WIDTH);
                    state  <= ST_RUN;
                end else if (start && op == OP_MTHI) begin
                    hi   <= a;
                    done <= 1'b1;
                end else if (start && op == OP_MTLO) begin
                    lo   <= a;
                    done <= 1'b1;
                end
            end else if (state == ST_RUN) begin
                acc <= acc_nxt;
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1))
                    state <= ST_FIX;
            end else begin
                hi    <= hi_fix;
                lo    <= lo_fix;
                done  <= 1'b1;
                dbz   <= is_div && zdiv;
                state <= ST_IDLE;
            end
        end
    end
    assign busy = state != ST_IDLE;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit; divide checks follow MULDIV_DIV_EN
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n_vec = 0;
    int          n_err = 0;
    int          lat;
    int          bcnt;
    int          dcnt;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // issue at the current negedge, scramble operands afterwards, optionally poke a start mid-flight
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int poke,
                         output int l, output int bc);
        op = o; a = x; b = y; start = 1'b1;
        l = 0; bc = 0;
        do begin
            @(negedge clk);
            l++;
            start = (l == poke);
            op    = start ? 3'd1 : o;
            a     = start ? 32'd3 : ~x;
            b     = start ? 32'd3 : ~y;
            if (busy) bc++;
        end while (!done && l < 100);
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(dbz), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op(3'd0, 32'hFFFFFFFD, 32'd5, 0, lat, bcnt);
        check("mult_lat", 64'(lat), 64'd34);
        check("mult_busy", 64'(bcnt), 64'd33);
        check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        check("mult_dbz", 64'(dbz), 64'd0);

        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, bcnt);
        check("multu_lat", 64'(lat), 64'd34);
        check("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
        check("multu_dbz", 64'(dbz), 64'd0);
        @(negedge clk);
        check("multu_done_clr", 64'(done), 64'd0);

`ifdef MULDIV_DIV_EN
        do_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, lat, bcnt);
        check("div_lat", 64'(lat), 64'd34);
        check("div_m7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, lat, bcnt);
        check("div_min_m1", {hi, lo}, 64'h00000000_80000000);
        check("div_min_dbz", 64'(dbz), 64'd0);
        do_op(3'd2, 32'd7, 32'hFFFFFFFE, 0, lat, bcnt);
        check("div_7_m2", {hi, lo}, 64'h00000001_FFFFFFFD);
        do_op(3'd3, 32'd100, 32'd7, 0, lat, bcnt);
        check("divu_100_7", {hi, lo}, 64'h00000002_0000000E);
        do_op(3'd3, 32'd7, 32'd0, 0, lat, bcnt);
        check("dbz_lat", 64'(lat), 64'd34);
        check("dbz_hilo", {hi, lo}, 64'h00000007_FFFFFFFF);
        check("dbz_flag", 64'(dbz), 64'd1);
        @(negedge clk);
        check("dbz_clr", 64'(dbz), 64'd0);
`else
        op = 3'd3; a = 32'd7; b = 32'd0; start = 1'b1;
        bcnt = 0; dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bcnt++;
            if (done) dcnt++;
        end
        check("nodiv_busy", 64'(bcnt), 64'd0);
        check("nodiv_done", 64'(dcnt), 64'd0);
        check("nodiv_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
`endif

        op = 3'd4; a = 32'h12345678; start = 1'b1;
        @(negedge clk);
        check("mthi_done", 64'(done), 64'd1);
        check("mthi_hi", 64'(hi), 64'h12345678);
        op = 3'd5; a = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_done", 64'(done), 64'd1);
        check("mtlo_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
        @(negedge clk);
        check("mtlo_done_clr", 64'(done), 64'd0);

        do_op(3'd0, 32'd7, 32'hFFFFFFFA, 5, lat, bcnt);
        check("poke_lat", 64'(lat), 64'd34);
        check("poke_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);
        @(negedge clk);
        check("poke_idle", 64'({busy, done}), 64'd0);

        op = 3'd1; a = 32'd5; b = 32'd6; start = 1'b1;
        dcnt = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) rst = 1'b0;
            if (k == 11) begin
                check("mrst_busy", 64'(busy), 64'd0);
                check("mrst_hilo", {hi, lo}, 64'd0);
                rst = 1'b1;
            end
            if (done) dcnt++;
        end
        check("mrst_nodone", 64'(dcnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Successor to the single-cycle inferred multiplier plus HI/LO register pair in the pipelined MIPS core. Adds signed/unsigned divide, configurable width and a start/busy/done handshake.
- Sits beside the ALU in the E stage. The hazard logic stalls F/D/E while busy is high; the W-stage hilo mux reads hi/lo directly.

Parameters:
- WIDTH, 32, operand width and HI/LO register width; even, >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved.
- a  input  WIDTH  operand A (rs); dividend for divides; data for MTHI/MTLO.
- b  input  WIDTH  operand B (rt); divisor for divides.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; hi/lo are valid in the same cycle.
- dbz  output  1  divide-by-zero flag; qualified by done.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst==0 at an edge), including mid-operation:
  - state=IDLE, counter=0, busy=0, done=0, dbz=0, hi=0, lo=0.
  - Any in-flight result is discarded.
- States: IDLE, RUN, FIX.
  - IDLE, start=1, op in 0-3:
    - Latch operands.
    - Signed ops (MULT, DIV): latch magnitudes and record result sign and remainder sign.
    - Load counter=WIDTH; go to RUN.
  - IDLE, start=1, op=4/5: write a to hi (op 4) or lo (op 5) at that edge; done=1 next cycle; stay in IDLE.
  - IDLE, start=1, op=6/7: ignored; no done.
  - RUN: one radix-2 step per cycle; decrement counter; at counter==1 go to FIX.
    - Multiply: shift-add on a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract; quotient in low half, remainder in high half.
  - FIX:
    - Apply two's-complement sign correction.
    - Write hi/lo; pulse done for the following cycle; go to IDLE.
- Latency for ops 0-3:
  - start sampled at edge N; hi/lo updated and done=1 in the cycle after edge N+WIDTH+1.
  - busy=1 from edge N through edge N+WIDTH+1 (WIDTH+1 cycles).
  - A new start is accepted in the done cycle.
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Boundary cases:
  - Divisor==0: hi=a, lo=all ones, dbz=1 with done. Latency is unchanged (no early exit).
  - Signed MIN / -1: lo=MIN, hi=0, dbz=0.
  - start while busy: ignored, with no effect on the operation in flight. The pipeline guarantees a stall, so no queueing is required.
  - Operands changing after the start edge: no effect, because they are latched.
  - hi/lo hold their value in every cycle not written.

Optional Feature:
- Macro: MULDIV_DIV_EN.
- Defined: behaviour exactly as above.
- Undefined:
  - Divide datapath and dbz logic are not synthesised; dbz is tied to 0.
  - op 2/3 are treated as reserved: ignored, no busy, no done.
  - Multiply and MTHI/MTLO are unaffected.

Decomposition:
- Shared package muldiv_pkg: op encodings (OP_MULT..OP_MTLO) and the state encoding (ST_IDLE, ST_RUN, ST_FIX).
- One sub-module, muldiv_step: combinational single-iteration datapath.
  - Inputs: accumulator, operand, mode.
  - Output: next accumulator.
  - The top level holds the FSM, counter, sign bits and HI/LO registers.

Test Plan:
- WIDTH=32, MULT a=FFFFFFFD (-3), b=5 -> done 34 cycles after start; hi=FFFFFFFF, lo=FFFFFFF1; busy high for 33 cycles.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001, dbz=0.
- DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); then DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
- DIVU a=7, b=0 -> hi=00000007, lo=FFFFFFFF, dbz=1 on the done cycle and 0 afterwards; repeat with MULTIV_DIV_EN undefined -> no busy, no done, hi/lo unchanged.
- MTHI a=12345678, then MTLO a=9ABCDEF0 on the next cycle -> each gives done one cycle later; hi=12345678, lo=9ABCDEF0. Then MULT started, and start with new operands asserted mid-operation -> ignored, and the original product is written.
- MULTU started, rst=0 at cycle 10 -> next cycle busy=0, hi=lo=0, and no done pulse at the original completion time.
